mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single unified RAM port between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the pipelined core.
- Latches one request at a time, sequences the RAM handshake, and returns a registered ready pulse plus load data to the winning requester.
- Data has priority, with a starvation guard for fetch and a timeout guard for a hung RAM.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while iREN is pending before fetch is forced to win.
- TIMEOUT, 16: BUSY cycles without ramack before the transaction is aborted.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request; held until iready.
- iaddr  in  32  instruction word address.
- dREN  in  1  data read request; held until dready.
- dWEN  in  1  data write request; held until dready.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- iready  out  1  one-cycle pulse: instruction transaction done.
- iload  out  32  instruction word; valid when iready=1.
- dready  out  1  one-cycle pulse: data transaction done.
- dload  out  32  data read value; valid when dready=1 on reads.
- merr  out  1  one-cycle pulse with the ready pulse of a timed-out transaction.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid with ramack.
- ramack  in  1  RAM completion; one-cycle pulse.

Behaviour:
- Clock and reset: single clock CLK; reset RST is synchronous and active-high, sampled on posedge CLK only.
- Reset state: FSM=IDLE. iready, dready and merr are 0. iload and dload are 0. All ram* outputs are 0. Streak and timeout counters are 0.
- FSM states:
  - IDLE: no transaction in flight.
  - IBUSY: instruction read in progress.
  - DBUSY: data read or write in progress.
- Request masking: in IDLE, a requester whose ready is high this cycle has its request ignored. This prevents re-granting a request still held in the cycle it completes.
- Grant in IDLE, evaluated on masked requests:
  - If iREN and streak==MAX_DSTREAK: go to IBUSY.
  - Else if dREN or dWEN: go to DBUSY.
  - Else if iREN: go to IBUSY.
  - Else stay in IDLE.
- Latching on grant: the winning address, op and store data are captured. ram* outputs are driven only from latched values, so requester inputs may change freely after grant.
- dREN and dWEN both high: treated as a write.
- RAM outputs in IBUSY: ramREN=1.
- RAM outputs in DBUSY: ramREN or ramWEN=1 per latched op.
- RAM outputs in IDLE: all ram* outputs are 0.
- Completion: ramack in BUSY moves the FSM to IDLE at the next edge, with ramload captured into iload or dload (dload unchanged on writes). The matching ready output pulses for exactly one cycle, in the cycle after ramack.
- Latency: request seen in IDLE at cycle 0 → ram strobe at cycle 1 → ramack at cycle k≥1 → ready at cycle k+1. Minimum 2 cycles.
- Streak counter:
  - Increments on each data grant while iREN is high, saturating at MAX_DSTREAK.
  - Clears on an instruction grant.
  - Clears on a data grant with iREN low.
- Timeout:
  - The timeout counter clears on entry to BUSY and increments each BUSY cycle without ramack.
  - At TIMEOUT, the FSM returns to IDLE. The owner's ready pulses with merr=1, and its load reads 0.
  - A ramack arriving in the same cycle as the timeout wins; no error is raised.
- ramack while IDLE: ignored.
- Request dropped mid-transaction: the RAM access still completes and the ready pulse is still issued; the requester ignores it.
- Reset mid-transaction: the transaction is abandoned, no ready pulse is issued, and all strobes drop at the reset edge.
- Back-to-back: a pending other-side request is granted in the IDLE cycle that coincides with the previous ready pulse. No idle bubble beyond that one IDLE cycle.

Test Plan:
- Instruction read: reset, then iREN=1 with iaddr=0x100, RAM acks 2 cycles after strobe with 0x8C010004 → ramREN is high for 2 cycles; iready pulses once with iload=0x8C010004; dready stays 0.
- Simultaneous requests: iREN and dREN both high in IDLE → data is granted first (ramaddr=daddr); after dready, fetch is granted in the next IDLE cycle; iready follows.
- Write with both strobes: dREN=1 and dWEN=1, daddr=0x200, dstore=0xCAFEF00D → ramWEN=1, ramREN=0, ramstore=0xCAFEF00D; dready pulses; dload is unchanged.
- Starvation: with MAX_DSTREAK=4, data requests continuously and iREN is held → exactly 4 data grants, then 1 instruction grant, then data again.
- Timeout: ramack never asserted → after 16 BUSY cycles, dready=1, merr=1, dload=0; the FSM is back in IDLE. Repeat with ramack in the timeout cycle → merr=0 and load data is valid.
- Reset mid-operation: RST asserted in the DBUSY cycle before ramack → no ready pulse; all outputs are 0 the next cycle; a later ramack is ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for the unified RAM port shared by instruction fetch and data access.
// Data wins by default; a streak limit keeps fetch from starving and a timeout aborts a hung RAM.
module mem_arbiter #(
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        iready,
   output logic [31:0] iload,
   output logic        dready,
   output logic [31:0] dload,
   output logic        merr,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramack
);
   // state | meaning
   // IDLE  | no transaction in flight
   // IBUSY | instruction read in progress
   // DBUSY | data read or write in progress
   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

   localparam int SW = $clog2(MAX_DSTREAK + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          r_state;
   state_t          w_next;
   logic            r_wr;
   logic [31:0]     r_addr;
   logic [31:0]     r_store;
   logic [SW-1:0]   r_streak;
   logic [TW-1:0]   r_tmo;
   logic            w_ireq;
   logic            w_dreq;
   logic            w_grant_i;
   logic            w_grant_d;
   logic            w_timeout;

   // A requester still holding its request in its own completion cycle is not re-granted.
   assign w_ireq    = iREN & ~iready;
   assign w_dreq    = (dREN | dWEN) & ~dready;
   assign w_timeout = (r_state != IDLE) && !ramack && (r_tmo == TW'(TIMEOUT - 1));

   always_comb begin
      w_next    = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      case (r_state)
         IDLE: begin
            if (w_ireq && r_streak == SW'(MAX_DSTREAK)) begin
               w_grant_i = 1'b1;
               w_next    = IBUSY;
            end else if (w_dreq) begin
               w_grant_d = 1'b1;
               w_next    = DBUSY;
            end else if (w_ireq) begin
               w_grant_i = 1'b1;
               w_next    = IBUSY;
            end
         end
         IBUSY: begin
            ramREN  = 1'b1;
            ramaddr = r_addr;
            if (ramack || w_timeout) w_next = IDLE;
         end
         DBUSY: begin
            ramREN  = ~r_wr;
            ramWEN  = r_wr;
            ramaddr = r_addr;
            if (r_wr) ramstore = r_store;
            if (ramack || w_timeout) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_store  <= '0;
         r_streak <= '0;
         r_tmo    <= '0;
         iready   <= 1'b0;
         dready   <= 1'b0;
         merr     <= 1'b0;
         iload    <= '0;
         dload    <= '0;
      end else begin
         r_state <= w_next;
         iready  <= 1'b0;
         dready  <= 1'b0;
         merr    <= 1'b0;
         if (w_grant_i) begin
            r_addr   <= iaddr;
            r_wr     <= 1'b0;
            r_tmo    <= '0;
            r_streak <= '0;
         end else if (w_grant_d) begin
            r_addr  <= daddr;
            r_wr    <= dWEN;
            r_store <= dstore;
            r_tmo   <= '0;
            if (!iREN)
               r_streak <= '0;
            else if (r_streak != SW'(MAX_DSTREAK))
               r_streak <= r_streak + 1'b1;
         end else if (r_state != IDLE) begin
            // A late ack in the timeout cycle still completes the transfer normally.
            if (ramack) begin
               if (r_state == IBUSY) begin
                  iready <= 1'b1;
                  iload  <= ramload;
               end else begin
                  dready <= 1'b1;
                  if (!r_wr) dload <= ramload;
               end
            end else if (w_timeout) begin
               merr <= 1'b1;
               if (r_state == IBUSY) begin
                  iready <= 1'b1;
                  iload  <= '0;
               end else begin
                  dready <= 1'b1;
                  dload  <= '0;
               end
            end else begin
               r_tmo <= r_tmo + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, hand-built corner sequences,
// then random traffic checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
   localparam int MAXS = 4;
   localparam int TMO  = 16;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN, ramack;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic        iready, dready, merr, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.MAX_DSTREAK(MAXS), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iready(iready), .iload(iload), .dready(dready), .dload(dload), .merr(merr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramack(ramack)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        i;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] store;
      int          delay;      // strobe cycle carrying ramack; 0 = never
      logic [31:0] load;
      logic        exp_ren;
      logic        exp_wen;
      logic        exp_merr;
      logic [31:0] exp_load;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ramREN"}, ramREN, 0);
      chk({tag, "_ramWEN"}, ramWEN, 0);
      chk({tag, "_ramaddr"}, ramaddr, 0);
      chk({tag, "_ramstore"}, ramstore, 0);
      chk({tag, "_iready"}, iready, 0);
      chk({tag, "_dready"}, dready, 0);
      chk({tag, "_merr"}, merr, 0);
      chk({tag, "_iload"}, iload, 0);
      chk({tag, "_dload"}, dload, 0);
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      int n;
      int w;
      string t;
      t = $sformatf("t%0d", idx);
      iREN   = v.i;
      iaddr  = v.i ? v.addr : 32'hDEAD0000;
      dREN   = v.rd;
      dWEN   = v.wr;
      daddr  = v.i ? 32'hDEAD0004 : v.addr;
      dstore = v.store;
      tick();
      w = 0;
      while (!(ramREN || ramWEN) && w < 4) begin
         tick();
         w++;
      end
      chk({t, "_ramREN"}, ramREN, v.exp_ren);
      chk({t, "_ramWEN"}, ramWEN, v.exp_wen);
      if (v.exp_wen) chk({t, "_ramstore"}, ramstore, v.store);
      // requester inputs wander after grant; RAM side must keep the latched values
      iaddr  = $urandom;
      daddr  = $urandom;
      dstore = $urandom;
      n = 0;
      while ((ramREN || ramWEN) && n < 40) begin
         n++;
         chk({t, "_ramaddr"}, ramaddr, v.addr);
         ramack  = (v.delay != 0 && n == v.delay);
         ramload = ramack ? v.load : $urandom;
         tick();
      end
      ramack = 1'b0;
      chk({t, "_strobe_cycles"}, n, (v.delay != 0) ? v.delay : TMO);
      chk({t, "_ready"}, v.i ? iready : dready, 1);
      chk({t, "_other_ready"}, v.i ? dready : iready, 0);
      chk({t, "_merr"}, merr, v.exp_merr);
      chk({t, "_load"}, v.i ? iload : dload, v.exp_load);
      tick();
      chk({t, "_no_regrant"}, ramREN | ramWEN, 0);
      chk({t, "_ready_pulse"}, iready | dready | merr, 0);
      iREN = 1'b0;
      dREN = 1'b0;
      dWEN = 1'b0;
      tick();
   endtask

   // reference model state
   bit          m_busy, m_own_d, m_wr;
   logic [31:0] m_addr, m_store;
   int          m_cnt, m_streak, ack_wait;
   bit          e_ir, e_dr, e_merr;
   logic [31:0] e_iload, e_dload;
   bit          ir_req, d_req, d_rd, d_wr;
   int          ir_gap, d_gap;
   logic [31:0] ir_addr, d_addr, d_store;

   function automatic int pick_delay();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) return TMO + 1 + $urandom_range(0, 4);
      if (r == 1) return TMO;
      return $urandom_range(1, 4);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      string seq;
      RST = 1'b1;
      iREN = 0; dREN = 0; dWEN = 0; ramack = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
      tick();
      tick();
      chk_all_zero("reset");
      RST = 1'b0;
      tick();

      //          i  rd wr addr          store         dly  load          ren wen merr exp_load
      tbl[0] = '{1, 0, 0, 32'h100, 32'h0,        2,   32'h8C010004, 1,  0,  0,   32'h8C010004};
      tbl[1] = '{0, 1, 0, 32'h040, 32'h0,        1,   32'h12345678, 1,  0,  0,   32'h12345678};
      tbl[2] = '{0, 1, 1, 32'h200, 32'hCAFEF00D, 3,   32'h0BADBEEF, 0,  1,  0,   32'h12345678};
      tbl[3] = '{0, 1, 0, 32'h044, 32'h0,        0,   32'h0,        1,  0,  1,   32'h0};
      tbl[4] = '{0, 1, 0, 32'h048, 32'h0,        TMO, 32'hA5A50016, 1,  0,  0,   32'hA5A50016};
      tbl[5] = '{1, 0, 0, 32'h104, 32'h0,        0,   32'h0,        1,  0,  1,   32'h0};
      tbl[6] = '{0, 0, 1, 32'h204, 32'h13572468, 1,   32'hFFFFFFFF, 0,  1,  0,   32'hA5A50016};
      for (int k = 0; k < 7; k++) run_txn(tbl[k], k);

      // simultaneous requests: data first, fetch in the dready cycle
      iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h400;
      tick();
      chk("sim_d_first_addr", ramaddr, 32'h400);
      chk("sim_d_first_ren", ramREN, 1);
      ramack = 1; ramload = 32'h11110000;
      tick();
      ramack = 0; dREN = 0;
      chk("sim_dready", dready, 1);
      chk("sim_dload", dload, 32'h11110000);
      tick();
      chk("sim_i_next_ren", ramREN, 1);
      chk("sim_i_next_addr", ramaddr, 32'h300);
      ramack = 1; ramload = 32'h22220000;
      tick();
      ramack = 0; iREN = 0;
      chk("sim_iready", iready, 1);
      chk("sim_iload", iload, 32'h22220000);
      tick();

      // starvation guard: fetch present at each data grant, absent at completions
      seq = "DDDDID";
      for (int k = 0; k < 6; k++) begin
         iREN = 1; iaddr = 32'h600; dREN = 1; daddr = 32'h500 + k;
         tick();
         chk($sformatf("starve_%0d_addr", k), ramaddr,
             (seq[k] == "I") ? 32'h600 : 32'h500 + k);
         iREN = 0; dREN = 0;
         ramack = 1; ramload = $urandom;
         tick();
         ramack = 0;
         tick();
      end

      // reset in the middle of a data transaction
      dREN = 1; daddr = 32'h700;
      tick();
      chk("rst_busy_ren", ramREN, 1);
      tick();
      RST = 1;
      tick();
      chk_all_zero("rst_mid");
      RST = 0; dREN = 0; ramack = 1; ramload = 32'h77777777;
      tick();
      ramack = 0;
      chk_all_zero("rst_late_ack");

      // random traffic against the reference model
      m_busy = 0; m_streak = 0; e_ir = 0; e_dr = 0; e_merr = 0;
      e_iload = 0; e_dload = 0;
      ir_req = 0; ir_gap = 1; d_req = 0; d_gap = 0; ir_addr = 0;
      d_addr = 0; d_store = 0; d_rd = 0; d_wr = 0; m_wr = 0; m_own_d = 0;
      m_addr = 0; m_store = 0; m_cnt = 0; ack_wait = 0;
      for (int c = 0; c < 3000; c++) begin
         bit n_ir, n_dr, n_merr, ireq, dreq;
         chk("rnd_ramREN", ramREN, m_busy && (!m_own_d || !m_wr));
         chk("rnd_ramWEN", ramWEN, m_busy && m_own_d && m_wr);
         chk("rnd_ramaddr", ramaddr, m_busy ? m_addr : 32'h0);
         if (m_busy && m_own_d && m_wr) chk("rnd_ramstore", ramstore, m_store);
         chk("rnd_iready", iready, e_ir);
         chk("rnd_dready", dready, e_dr);
         chk("rnd_merr", merr, e_merr);
         if (e_ir) chk("rnd_iload", iload, e_iload);
         if (e_dr) chk("rnd_dload", dload, e_dload);

         if (m_busy) begin
            ack_wait--;
            ramack = (ack_wait == 0);
         end else begin
            ramack = ($urandom_range(0, 7) == 0);
         end
         ramload = $urandom;

         if (e_ir) begin
            ir_req = 0; ir_gap = $urandom_range(0, 2); iREN = $urandom_range(0, 1);
         end else if (ir_req) begin
            iREN = 1;
         end else if (ir_gap == 0) begin
            ir_req = 1; ir_addr = $urandom; iREN = 1;
         end else begin
            ir_gap--; iREN = 0;
         end
         iaddr = iREN ? ir_addr : $urandom;

         if (e_dr) begin
            d_req = 0; d_gap = $urandom_range(0, 1);
            dREN = d_rd && ($urandom_range(0, 1) == 1);
            dWEN = d_wr && dREN == d_rd && ($urandom_range(0, 1) == 1);
         end else if (d_req) begin
            dREN = d_rd; dWEN = d_wr;
         end else if (d_gap == 0) begin
            int k;
            k = $urandom_range(0, 2);
            d_req = 1; d_rd = (k != 1); d_wr = (k != 0);
            d_addr = $urandom; d_store = $urandom;
            dREN = d_rd; dWEN = d_wr;
         end else begin
            d_gap--; dREN = 0; dWEN = 0;
         end
         daddr  = (dREN || dWEN) ? d_addr : $urandom;
         dstore = (dREN || dWEN) ? d_store : $urandom;

         n_ir = 0; n_dr = 0; n_merr = 0;
         if (m_busy) begin
            if (ramack) begin
               m_busy = 0;
               if (m_own_d) begin
                  n_dr = 1;
                  if (!m_wr) e_dload = ramload;
               end else begin
                  n_ir = 1; e_iload = ramload;
               end
            end else begin
               m_cnt++;
               if (m_cnt == TMO) begin
                  m_busy = 0; n_merr = 1;
                  if (m_own_d) begin n_dr = 1; e_dload = 0; end
                  else begin n_ir = 1; e_iload = 0; end
               end
            end
         end else begin
            ireq = iREN && !e_ir;
            dreq = (dREN || dWEN) && !e_dr;
            if (ireq && (m_streak == MAXS || !dreq)) begin
               m_busy = 1; m_own_d = 0; m_wr = 0; m_addr = iaddr;
               m_cnt = 0; m_streak = 0; ack_wait = pick_delay();
            end else if (dreq) begin
               m_busy = 1; m_own_d = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
               m_cnt = 0; ack_wait = pick_delay();
               m_streak = iREN ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end
         end
         e_ir = n_ir; e_dr = n_dr; e_merr = n_merr;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
